i2c_codec_target: RTL and testbench
===================================

// Module: i2c_codec_target
// PURPOSE
//   Synthesizable I2C write-only target that mirrors the WM8731 control port.
//   Receives 3-byte writes from the codec controller: device address, then two data bytes.
//   Produces a 7-bit register address, 9-bit data and a one-cycle valid strobe.
//   Used as a loop-back codec stand-in on the FPGA and as a synthesizable bench target.
// PARAMETERS
//   DEV_ADDR     7'h1A  7-bit target address (0x34 on the wire with R/W=0)
//   SYNC_STAGES  2      flip-flop synchronizer depth on i2c_sclk and i2c_sdat_in (>=2)
// PORTS
//   clk           in   1   system clock; sole clock domain
//   reset         in   1   synchronous, active-high reset
//   i2c_sclk      in   1   I2C clock from the bus (asynchronous to clk)
//   i2c_sdat_in   in   1   I2C data as seen on the bus (asynchronous)
//   i2c_sdat_oe   out  1   1 = pull SDA low (ACK); 0 = release the line (open-drain)
//   wr_valid      out  1   one-cycle pulse: a complete write was received
//   wr_reg_addr   out  7   register address = byte1[7:1]
//   wr_data       out  9   register data = {byte1[0], byte2[7:0]}
//   busy          out  1   high from START until STOP or until the target drops out
//   addr_nack     out  1   one-cycle pulse: address mismatch or R/W=1 was NACKed
// BEHAVIOUR
//   Reset values: i2c_sdat_oe=0, wr_valid=0, wr_reg_addr=0, wr_data=0, busy=0, addr_nack=0.
//     Reset mid-transfer discards all progress and returns the FSM to IDLE.
//   Input synchronization: both bus inputs pass through SYNC_STAGES flops.
//     Edges are detected on the synchronized signals against a one-cycle-delayed copy.
//   Bus events, all evaluated on the synchronized signals:
//     SCL rise = sample edge. SCL fall = drive edge.
//     START = SDA falls while SCL is high. STOP = SDA rises while SCL is high.
//   FSM states: IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE.
//   IDLE -> ADDR on START. Clear the bit counter and set busy=1.
//   ADDR, BYTE1, BYTE2: shift in SDA MSB-first on each SCL rise; count 8 bits.
//     On the SCL fall after bit 8, enter the matching ACK state.
//   ACK_A:
//     Address match and R/W=0: assert i2c_sdat_oe on entry; release it on the next SCL fall.
//       Then go to BYTE1.
//     Otherwise: keep i2c_sdat_oe=0, pulse addr_nack, go to IGNORE, set busy=0.
//   ACK_1: ACK as in ACK_A, then go to BYTE2.
//   ACK_2: ACK as in ACK_A, then go to IGNORE.
//     On the entry cycle, update wr_reg_addr/wr_data and pulse wr_valid for exactly one clk.
//   IGNORE: any further bytes are not ACKed and oe stays 0.
//     Wait here for STOP or repeated START.
//   STOP in any state -> IDLE, busy=0, i2c_sdat_oe=0 on the same cycle.
//     If STOP arrives before ACK_2, the partial bytes are discarded and no wr_valid is issued.
//   START in any non-IDLE state (repeated START) -> ADDR; the partial transfer is discarded.
//   Own-drive guard: SDA transitions caused by this block are never decoded as START/STOP.
//     START/STOP detection is suppressed while i2c_sdat_oe=1.
//   Simultaneous SCL and SDA change in one sample: treated as a data change, not START/STOP.
//   wr_reg_addr/wr_data hold their value until the next wr_valid.
//   Timing requirement: SCL high and low phases >= SYNC_STAGES+3 clk cycles each.
//     SDA must be stable across SCL rise.
// CONFIGURATION
//   I2CT_GLITCH_FILT_EN defined:
//     Adds a 3-sample majority filter after the synchronizers on both SCL and SDA.
//     Pulses of 1 clk width are rejected. Event latency grows by 2 clk.
//     Minimum SCL phase becomes SYNC_STAGES+5 clk.
//   Not defined: no filter; synchronizer outputs feed edge detection directly.
// TESTING
//   1 START, 0x34, 0x1E, 0x00, STOP
//     -> three ACKs; wr_valid once; wr_reg_addr=0x0F, wr_data=0x000; busy low after STOP.
//   2 START, 0x34, 0x0D, 0x9F, STOP
//     -> wr_reg_addr=0x06, wr_data=0x19F; exactly one wr_valid pulse.
//   3 START, 0x36 (wrong address), then 2 bytes, STOP
//     -> no ACK on any byte; addr_nack pulses once; no wr_valid. Repeat with 0x35 (R/W=1): same.
//   4 START, 0x34, 0x1E, STOP
//     -> two ACKs; no wr_valid; outputs keep their previous values; FSM in IDLE.
//   5 START, 0x34, 0x12, repeated START, 0x34, 0x0C, 0x01, STOP
//     -> single wr_valid with wr_reg_addr=0x06, wr_data=0x001.
//   6 reset asserted during BYTE2 of a valid write
//     -> all outputs return to reset values next clk; no wr_valid.
//   6b (run only with I2CT_GLITCH_FILT_EN) inject a 1-clk SDA low glitch while SCL is high
//     -> no START is detected; busy stays 0.

Source files
------------

// File: rtl/i2c_codec_target.sv
// Write-only I2C target mirroring the WM8731 control port: START, address, two data bytes, STOP.
// Optional I2CT_GLITCH_FILT_EN adds a 3-sample majority filter after the synchronizers.
`timescale 1ns/1ps
module i2c_codec_target #(
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_sclk,
  input  logic       i2c_sdat_in,
  output logic       i2c_sdat_oe,
  output logic       wr_valid,
  output logic [6:0] wr_reg_addr,
  output logic [8:0] wr_data,
  output logic       busy,
  output logic       addr_nack
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE
  } state_t;

  state_t state;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_d, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;
  logic [7:0] byte1;

  // Synchronizers reset to the idle bus level so reset release never looks like an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], i2c_sclk};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], i2c_sdat_in};
    end
  end

`ifdef I2CT_GLITCH_FILT_EN
  logic [2:0] scl_hist, sda_hist;

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_hist <= 3'b111;
      sda_hist <= 3'b111;
    end else begin
      scl_hist <= {scl_hist[1:0], scl_sync[SYNC_STAGES-1]};
      sda_hist <= {sda_hist[1:0], sda_sync[SYNC_STAGES-1]};
    end
  end

  assign scl_s = (scl_hist[0] & scl_hist[1]) | (scl_hist[0] & scl_hist[2]) | (scl_hist[1] & scl_hist[2]);
  assign sda_s = (sda_hist[0] & sda_hist[1]) | (sda_hist[0] & sda_hist[2]) | (sda_hist[1] & sda_hist[2]);
`else
  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_s;
      sda_d <= sda_s;
    end
  end

  // START/STOP need SCL steady high across the sample and are blind while we pull SDA.
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s & ~i2c_sdat_oe;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s & ~i2c_sdat_oe;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= 4'd0;
      shreg       <= 8'h00;
      byte1       <= 8'h00;
      i2c_sdat_oe <= 1'b0;
      wr_valid    <= 1'b0;
      wr_reg_addr <= 7'h00;
      wr_data     <= 9'h000;
      busy        <= 1'b0;
      addr_nack   <= 1'b0;
    end else begin
      wr_valid  <= 1'b0;
      addr_nack <= 1'b0;
      if (stop_det) begin
        state       <= IDLE;
        busy        <= 1'b0;
        i2c_sdat_oe <= 1'b0;
      end else if (start_det) begin
        state       <= ADDR;
        bit_cnt     <= 4'd0;
        busy        <= 1'b1;
        i2c_sdat_oe <= 1'b0;
      end else begin
        case (state)
          ADDR, BYTE1, BYTE2: begin
            if (scl_rise) begin
              shreg   <= {shreg[6:0], sda_s};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= 4'd0;
              if (state == ADDR) begin
                // A read request is refused just like a foreign address.
                if (shreg == {DEV_ADDR, 1'b0}) begin
                  state       <= ACK_A;
                  i2c_sdat_oe <= 1'b1;
                end else begin
                  state     <= IGNORE;
                  addr_nack <= 1'b1;
                  busy      <= 1'b0;
                end
              end else if (state == BYTE1) begin
                byte1       <= shreg;
                state       <= ACK_1;
                i2c_sdat_oe <= 1'b1;
              end else begin
                state       <= ACK_2;
                i2c_sdat_oe <= 1'b1;
                wr_valid    <= 1'b1;
                wr_reg_addr <= byte1[7:1];
                wr_data     <= {byte1[0], shreg};
              end
            end
          end
          ACK_A: begin
            if (scl_fall) begin
              i2c_sdat_oe <= 1'b0;
              state       <= BYTE1;
            end
          end
          ACK_1: begin
            if (scl_fall) begin
              i2c_sdat_oe <= 1'b0;
              state       <= BYTE2;
            end
          end
          ACK_2: begin
            if (scl_fall) begin
              i2c_sdat_oe <= 1'b0;
              state       <= IGNORE;
            end
          end
          IDLE, IGNORE: begin
            i2c_sdat_oe <= 1'b0;
          end
          default: begin
            state       <= IDLE;
            i2c_sdat_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_codec_target.sv
// Directed bench for i2c_codec_target: drives an I2C controller model on a wired-AND SDA.
`timescale 1ns/1ps
module tb_i2c_codec_target;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       i2c_sdat_oe;
  logic       wr_valid;
  logic [6:0] wr_reg_addr;
  logic [8:0] wr_data;
  logic       busy;
  logic       addr_nack;

  int n_checks = 0;
  int n_fail = 0;
  int valid_cnt = 0;
  int nack_cnt = 0;

  always #5 clk = ~clk;

  // Open-drain bus: either side pulling low wins.
  assign sda_bus = sda_m & ~i2c_sdat_oe;

  i2c_codec_target dut (
    .clk(clk),
    .reset(reset),
    .i2c_sclk(scl_m),
    .i2c_sdat_in(sda_bus),
    .i2c_sdat_oe(i2c_sdat_oe),
    .wr_valid(wr_valid),
    .wr_reg_addr(wr_reg_addr),
    .wr_data(wr_data),
    .busy(busy),
    .addr_nack(addr_nack)
  );

  // Counting high cycles, so a stretched strobe shows up as an extra count.
  always @(negedge clk) begin
    if (wr_valid === 1'b1) valid_cnt++;
    if (addr_nack === 1'b1) nack_cnt++;
  end

  task automatic wait_q();
    repeat (8) @(negedge clk);
  endtask

  task automatic bus_start();
    if (scl_m == 1'b0) begin
      sda_m = 1'b1; wait_q();
      scl_m = 1'b1; wait_q();
    end
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q(); wait_q();
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; wait_q();
    scl_m = 1'b1; wait_q(); wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    acked = (sda_bus == 1'b0);
    wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (i2c_sdat_oe !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_oe: got %b expected 0", i2c_sdat_oe); end
    n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", wr_valid); end
    n_checks++; if (wr_reg_addr !== 7'h00) begin n_fail++; $display("[TB] FAIL reset_addr: got %h expected 00", wr_reg_addr); end
    n_checks++; if (wr_data !== 9'h000) begin n_fail++; $display("[TB] FAIL reset_data: got %h expected 000", wr_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (addr_nack !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_nack: got %b expected 0", addr_nack); end
    reset = 1'b0;
    wait_q();
  endtask

  task automatic test_write(input string tag, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [6:0] exp_addr, input logic [8:0] exp_data);
    logic a0, a1, a2;
    int v0, k0;
    v0 = valid_cnt; k0 = nack_cnt;
    bus_start();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL %s_busy_start: got %b expected 1", tag, busy); end
    send_byte(8'h34, a0);
    send_byte(b1, a1);
    send_byte(b2, a2);
    bus_stop();
    n_checks++; if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("[TB] FAIL %s_acks: got %b expected 111", tag, {a0, a1, a2}); end
    n_checks++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("[TB] FAIL %s_valid_cnt: got %0d expected 1", tag, valid_cnt - v0); end
    n_checks++; if (nack_cnt - k0 !== 0) begin n_fail++; $display("[TB] FAIL %s_nack_cnt: got %0d expected 0", tag, nack_cnt - k0); end
    n_checks++; if (wr_reg_addr !== exp_addr) begin n_fail++; $display("[TB] FAIL %s_addr: got %h expected %h", tag, wr_reg_addr, exp_addr); end
    n_checks++; if (wr_data !== exp_data) begin n_fail++; $display("[TB] FAIL %s_data: got %h expected %h", tag, wr_data, exp_data); end
    n_checks++; if (busy !== 1'b0 || i2c_sdat_oe !== 1'b0) begin n_fail++; $display("[TB] FAIL %s_idle: got busy=%b oe=%b expected 0 0", tag, busy, i2c_sdat_oe); end
  endtask

  task automatic test_bad_addr(input string tag, input logic [7:0] dev);
    logic a0, a1, a2;
    int v0, k0;
    v0 = valid_cnt; k0 = nack_cnt;
    bus_start();
    send_byte(dev, a0);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL %s_busy_drop: got %b expected 0", tag, busy); end
    send_byte(8'h1E, a1);
    send_byte(8'h00, a2);
    bus_stop();
    n_checks++; if ({a0, a1, a2} !== 3'b000) begin n_fail++; $display("[TB] FAIL %s_acks: got %b expected 000", tag, {a0, a1, a2}); end
    n_checks++; if (nack_cnt - k0 !== 1) begin n_fail++; $display("[TB] FAIL %s_nack_cnt: got %0d expected 1", tag, nack_cnt - k0); end
    n_checks++; if (valid_cnt - v0 !== 0) begin n_fail++; $display("[TB] FAIL %s_valid_cnt: got %0d expected 0", tag, valid_cnt - v0); end
  endtask

  task automatic test_partial();
    logic a0, a1;
    int v0;
    v0 = valid_cnt;
    bus_start();
    send_byte(8'h34, a0);
    send_byte(8'h1E, a1);
    bus_stop();
    n_checks++; if ({a0, a1} !== 2'b11) begin n_fail++; $display("[TB] FAIL partial_acks: got %b expected 11", {a0, a1}); end
    n_checks++; if (valid_cnt - v0 !== 0) begin n_fail++; $display("[TB] FAIL partial_valid_cnt: got %0d expected 0", valid_cnt - v0); end
    n_checks++; if (wr_reg_addr !== 7'h06 || wr_data !== 9'h19F) begin n_fail++; $display("[TB] FAIL partial_hold: got %h/%h expected 06/19f", wr_reg_addr, wr_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL partial_busy: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic a0, a1, a2, a3, a4;
    int v0;
    v0 = valid_cnt;
    bus_start();
    send_byte(8'h34, a0);
    send_byte(8'h12, a1);
    bus_start();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL rstart_busy: got %b expected 1", busy); end
    send_byte(8'h34, a2);
    send_byte(8'h0C, a3);
    send_byte(8'h01, a4);
    bus_stop();
    n_checks++; if ({a0, a1, a2, a3, a4} !== 5'b11111) begin n_fail++; $display("[TB] FAIL rstart_acks: got %b expected 11111", {a0, a1, a2, a3, a4}); end
    n_checks++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("[TB] FAIL rstart_valid_cnt: got %0d expected 1", valid_cnt - v0); end
    n_checks++; if (wr_reg_addr !== 7'h06 || wr_data !== 9'h001) begin n_fail++; $display("[TB] FAIL rstart_result: got %h/%h expected 06/001", wr_reg_addr, wr_data); end
  endtask

  task automatic test_mid_reset();
    logic a0, a1;
    int v0;
    v0 = valid_cnt;
    bus_start();
    send_byte(8'h34, a0);
    send_byte(8'h1E, a1);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_busy_before: got %b expected 1", busy); end
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (wr_reg_addr !== 7'h00 || wr_data !== 9'h000) begin n_fail++; $display("[TB] FAIL midrst_regs: got %h/%h expected 00/000", wr_reg_addr, wr_data); end
    n_checks++; if ({busy, i2c_sdat_oe, wr_valid, addr_nack} !== 4'b0000) begin n_fail++; $display("[TB] FAIL midrst_flags: got %b expected 0000", {busy, i2c_sdat_oe, wr_valid, addr_nack}); end
    scl_m = 1'b1; sda_m = 1'b1;
    wait_q();
    reset = 1'b0;
    wait_q(); wait_q();
    n_checks++; if (valid_cnt - v0 !== 0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_after: got valid=%0d busy=%b expected 0 0", valid_cnt - v0, busy); end
  endtask

`ifdef I2CT_GLITCH_FILT_EN
  task automatic test_glitch();
    @(negedge clk);
    sda_m = 1'b0;
    @(negedge clk);
    sda_m = 1'b1;
    wait_q();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL glitch_busy: got %b expected 0", busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_write("t1", 8'h1E, 8'h00, 7'h0F, 9'h000);
    test_write("t2", 8'h0D, 8'h9F, 7'h06, 9'h19F);
    test_bad_addr("t3_wrong", 8'h36);
    test_bad_addr("t3_read", 8'h35);
    test_partial();
    test_back_to_back();
    test_mid_reset();
`ifdef I2CT_GLITCH_FILT_EN
    test_glitch();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
